// File: rtl/op_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : op_sched_pkg
// Purpose  : Shared types and constants for the two-port operation scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package op_sched_pkg;

  // Operand and result widths of the shared arithmetic engine
  localparam int OP_W  = 4;
  localparam int RES_W = 16;

  // Requester identifiers, also used as the grant id and last-served pointer
  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // Scheduler FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter2
// Purpose  : Combinational 2-way round-robin grant. On a tie the requester
//            that was not served last wins; the pointer lives in the parent.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter2
  import op_sched_pkg::*;
(
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last,
  output logic o_valid,
  output logic o_id
);

  // Requester 1 wins when alone, or on a tie when requester 0 was served last
  always_comb begin
    o_valid = i_req0 | i_req1;
    o_id    = REQ0;
    if (i_req1 && (!i_req0 || (i_last == REQ0))) begin
      o_id = REQ1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/op_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : op_scheduler
// Purpose  : Shares one start/done arithmetic engine between two requesters.
//            Round-robin grant, start pulse, done wait with watchdog abort,
//            and a one-cycle acknowledge carrying result/err/timeout.
// Revision : 1.0 - initial release
// ============================================================================
module op_scheduler
  import op_sched_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [OP_W-1:0]  a0,
  input  logic [OP_W-1:0]  b0,
  input  logic [OP_W-1:0]  a1,
  input  logic [OP_W-1:0]  b1,
  output logic             ack0,
  output logic             ack1,
  output logic [RES_W-1:0] result,
  output logic             err,
  output logic             timeout,
  output logic             busy,
  output logic             eng_start,
  output logic [OP_W-1:0]  eng_a,
  output logic [OP_W-1:0]  eng_b,
  input  logic [RES_W-1:0] eng_c,
  input  logic             eng_done,
  input  logic             eng_err
);

  localparam int WD_W = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] C_WD_LAST = WD_W'(TIMEOUT - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_gnt_id;
  logic             r_last;
  logic [WD_W-1:0]  r_wd;
  logic [OP_W-1:0]  r_eng_a;
  logic [OP_W-1:0]  r_eng_b;
  logic             r_eng_start;
  logic             r_ack0;
  logic             r_ack1;
  logic [RES_W-1:0] r_result;
  logic             r_err;
  logic             r_timeout;
  logic             r_busy;
  logic             w_gnt_valid;
  logic             w_gnt_id;
  logic             w_wd_limit;

  rr_arbiter2 u_arb (
    .i_req0  (req0),
    .i_req1  (req1),
    .i_last  (r_last),
    .o_valid (w_gnt_valid),
    .o_id    (w_gnt_id)
  );

  assign w_wd_limit = (r_wd == C_WD_LAST);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a done on the watchdog-limit cycle takes priority
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_gnt_valid) w_state_nxt = ISSUE;
      ISSUE:   w_state_nxt = WAIT;
      WAIT:    if (eng_done || w_wd_limit) w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Registered datapath: grant latch, watchdog, completion capture, pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_gnt_id    <= REQ0;
      r_last      <= REQ1;
      r_wd        <= '0;
      r_eng_a     <= '0;
      r_eng_b     <= '0;
      r_eng_start <= 1'b0;
      r_ack0      <= 1'b0;
      r_ack1      <= 1'b0;
      r_result    <= '0;
      r_err       <= 1'b0;
      r_timeout   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_eng_start <= 1'b0;
      r_ack0      <= 1'b0;
      r_ack1      <= 1'b0;
      r_busy      <= (w_state_nxt != IDLE);
      case (r_state)
        IDLE: begin
          if (w_gnt_valid) begin
            r_gnt_id    <= w_gnt_id;
            r_eng_a     <= (w_gnt_id == REQ1) ? a1 : a0;
            r_eng_b     <= (w_gnt_id == REQ1) ? b1 : b0;
            r_eng_start <= 1'b1;
          end
        end
        ISSUE: begin
          r_wd <= '0;
        end
        WAIT: begin
          if (eng_done) begin
            r_result  <= eng_c;
            r_err     <= eng_err;
            r_timeout <= 1'b0;
            r_ack0    <= (r_gnt_id == REQ0);
            r_ack1    <= (r_gnt_id == REQ1);
          end else if (w_wd_limit) begin
            r_result  <= '0;
            r_err     <= 1'b1;
            r_timeout <= 1'b1;
            r_ack0    <= (r_gnt_id == REQ0);
            r_ack1    <= (r_gnt_id == REQ1);
          end else begin
            r_wd <= r_wd + WD_W'(1);
          end
        end
        RESP: begin
          r_last <= r_gnt_id;
        end
        default: ;
      endcase
    end
  end

  assign ack0      = r_ack0;
  assign ack1      = r_ack1;
  assign result    = r_result;
  assign err       = r_err;
  assign timeout   = r_timeout;
  assign busy      = r_busy;
  assign eng_start = r_eng_start;
  assign eng_a     = r_eng_a;
  assign eng_b     = r_eng_b;

endmodule
`default_nettype wire

// File: tb/tb_op_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_op_scheduler
// Purpose  : Directed self-checking bench for op_scheduler with a simple
//            multiply engine model (C=A*B, err when A=15, programmable delay).
// Revision : 1.0 - initial release
// ============================================================================
module tb_op_scheduler;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [3:0]  a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic        ack0, ack1, err, timeout, busy, eng_start;
  logic [15:0] result;
  logic [3:0]  eng_a, eng_b;
  logic [15:0] eng_c = '0;
  logic        eng_done = 1'b0, eng_err = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // engine model controls
  int  delay = 1;
  bit  hang = 1'b0;
  int  ecnt = 0;
  logic [15:0] ea = '0, eb = '0;

  // event logs filled by watch()
  int          st_cyc[$];
  logic [3:0]  st_a[$];
  logic [3:0]  st_b[$];
  int          ak_id[$];
  int          ak_cyc[$];
  logic [15:0] ak_res[$];
  logic        ak_err[$];
  logic        ak_to[$];

  op_scheduler #(.TIMEOUT(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .req0      (req0),
    .req1      (req1),
    .a0        (a0),
    .b0        (b0),
    .a1        (a1),
    .b1        (b1),
    .ack0      (ack0),
    .ack1      (ack1),
    .result    (result),
    .err       (err),
    .timeout   (timeout),
    .busy      (busy),
    .eng_start (eng_start),
    .eng_a     (eng_a),
    .eng_b     (eng_b),
    .eng_c     (eng_c),
    .eng_done  (eng_done),
    .eng_err   (eng_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Engine model: latch operands on start, raise done for one cycle after 'delay' cycles
  always @(negedge clk) begin
    if (!reset) begin
      ecnt     = 0;
      eng_done = 1'b0;
    end else begin
      eng_done = 1'b0;
      if (eng_start) begin
        ea   = {12'd0, eng_a};
        eb   = {12'd0, eng_b};
        ecnt = hang ? 0 : delay;
      end else if (ecnt != 0) begin
        ecnt = ecnt - 1;
        if (ecnt == 0) begin
          eng_done = 1'b1;
          eng_c    = ea * eb;
          eng_err  = (ea == 16'd15);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {2'b00, ack0, ack1, err, timeout, busy, eng_start, result, eng_a, eng_b};
  endfunction

  // Observe a bounded number of cycles, logging starts and acks; requesters
  // drop req when acked unless 'hold', and all reqs drop once 'want' acks seen
  task automatic watch(input int max_cyc, input int want, input bit hold);
    st_cyc.delete(); st_a.delete(); st_b.delete();
    ak_id.delete(); ak_cyc.delete(); ak_res.delete(); ak_err.delete(); ak_to.delete();
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (eng_start) begin
        st_cyc.push_back(cyc); st_a.push_back(eng_a); st_b.push_back(eng_b);
      end
      if (ack0) begin
        ak_id.push_back(0); ak_cyc.push_back(cyc); ak_res.push_back(result);
        ak_err.push_back(err); ak_to.push_back(timeout);
        if (!hold) req0 = 1'b0;
      end
      if (ack1) begin
        ak_id.push_back(1); ak_cyc.push_back(cyc); ak_res.push_back(result);
        ak_err.push_back(err); ak_to.push_back(timeout);
        if (!hold) req1 = 1'b0;
      end
      if (want > 0 && ak_id.size() >= want) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req0  = 1'b0;
    req1  = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", outs(), 32'd0);
    reset = 1'b1;
  endtask

  initial begin
    do_reset();

    // Single request, engine delay 3
    delay = 3; hang = 1'b0;
    a0 = 4'd2; b0 = 4'd1; req0 = 1'b1;
    watch(20, 1, 1'b0);
    chk("single_starts", st_cyc.size(), 1);
    chk("single_eng_a", st_a[0], 2);
    chk("single_eng_b", st_b[0], 1);
    chk("single_acks", ak_id.size(), 1);
    chk("single_id", ak_id[0], 0);
    chk("single_result", ak_res[0], 2);
    chk("single_err", ak_err[0], 0);
    chk("single_to", ak_to[0], 0);
    chk("single_latency", ak_cyc[0] - st_cyc[0], 4);
    chk("single_idle", {busy, ack0, ack1}, 3'b000);

    // Tie after reset: requester 0 first, then requester 1 back-to-back
    do_reset();
    delay = 2;
    a0 = 4'd4; b0 = 4'd4; a1 = 4'd3; b1 = 4'd5;
    req0 = 1'b1; req1 = 1'b1;
    watch(30, 2, 1'b0);
    chk("tie_acks", ak_id.size(), 2);
    chk("tie_first_id", ak_id[0], 0);
    chk("tie_first_res", ak_res[0], 16);
    chk("tie_second_id", ak_id[1], 1);
    chk("tie_second_res", ak_res[1], 15);
    chk("tie_starts", st_cyc.size(), 2);
    chk("tie_b2b_gap", st_cyc[1] - ak_cyc[0], 2);

    // Engine error on requester 1
    delay = 2;
    a1 = 4'd15; b1 = 4'd8; req1 = 1'b1;
    watch(20, 1, 1'b0);
    chk("err_acks", ak_id.size(), 1);
    chk("err_id", ak_id[0], 1);
    chk("err_result", ak_res[0], 120);
    chk("err_err", ak_err[0], 1);
    chk("err_to", ak_to[0], 0);

    // Watchdog timeout: engine never answers
    hang = 1'b1;
    a0 = 4'd1; b0 = 4'd1; req0 = 1'b1;
    watch(30, 1, 1'b0);
    chk("to_acks", ak_id.size(), 1);
    chk("to_id", ak_id[0], 0);
    chk("to_latency", ak_cyc[0] - (st_cyc[0] + 1), TO);
    chk("to_result", ak_res[0], 0);
    chk("to_err", ak_err[0], 1);
    chk("to_flag", ak_to[0], 1);
    hang = 1'b0;

    // Fairness: both held high for 6 operations
    delay = 1;
    a0 = 4'd1; b0 = 4'd2; a1 = 4'd3; b1 = 4'd1;
    req0 = 1'b1; req1 = 1'b1;
    watch(60, 6, 1'b1);
    chk("fair_acks", ak_id.size(), 6);
    for (int i = 1; i < 6; i++) begin
      chk($sformatf("fair_alt%0d", i), 32'(ak_id[i] != ak_id[i-1]), 1);
      chk($sformatf("fair_res%0d", i), ak_res[i], (ak_id[i] == 1) ? 3 : 2);
    end

    // Reset during WAIT: outputs clear immediately, no ack
    hang = 1'b1;
    a1 = 4'd2; b1 = 4'd3; req1 = 1'b1;
    watch(4, 1, 1'b0);
    chk("rst_wait_started", st_cyc.size(), 1);
    chk("rst_wait_busy", busy, 1);
    chk("rst_wait_noack", ak_id.size(), 0);
    reset = 1'b0; req1 = 1'b0;
    #1;
    chk("rst_async_outs", outs(), 32'd0);
    watch(3, 0, 1'b0);
    chk("rst_hold_noack", ak_id.size(), 0);
    chk("rst_hold_outs", outs(), 32'd0);
    reset = 1'b1;
    hang = 1'b0; delay = 2;
    a0 = 4'd7; b0 = 4'd9; req0 = 1'b1;
    watch(20, 1, 1'b0);
    chk("post_rst_acks", ak_id.size(), 1);
    chk("post_rst_id", ak_id[0], 0);
    chk("post_rst_result", ak_res[0], 63);
    chk("post_rst_err", ak_err[0], 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/op_scheduler.md
# op_scheduler

Two-port scheduler that shares the single start/done arithmetic engine (4-bit A/B operands, 16-bit C result, error flag) between two independent requesters. It arbitrates round-robin, drives the engine's start pulse and operands, and waits for done. It returns the result and error flag to the granted requester with a one-cycle acknowledge, and aborts with a timeout error if the engine hangs. It sits between the requesting control logic and the engine, replacing the direct start/A/B wiring.

## Interface
- TIMEOUT, 64: maximum cycles spent in WAIT before forced completion (≥ 2).
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req0 / req1  input  1  request from requester 0 / 1; held high until its ack.
- a0, b0 / a1, b1  input  4 each  operands; stable while req is high.
- ack0 / ack1  output  1  one-cycle completion pulse to requester 0 / 1.
- result  output  16  engine result (or 0 on timeout), valid only while any ack is high.
- err  output  1  engine error or timeout, valid with ack.
- timeout  output  1  high with ack when completion was forced by the watchdog.
- busy  output  1  high in every state except IDLE.
- eng_start  output  1  one-cycle start pulse to the engine.
- eng_a, eng_b  output  4 each  operands to the engine, registered at grant.
- eng_c  input  16  engine result.
- eng_done  input  1  engine completion; the first cycle sampled high counts.
- eng_err  input  1  engine error, sampled with eng_done.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req is high, grant one and latch its operands into eng_a/eng_b and the grant id, then go to ISSUE.
- Arbitration: with one req high, that requester wins. With both high, the requester not served last wins. The last-served pointer resets to 1, so requester 0 wins the first tie.
- ISSUE: eng_start=1 for exactly this cycle, watchdog cleared, then go to WAIT.
- WAIT: the watchdog increments each cycle.
  - eng_done=1: capture eng_c into result and eng_err into err, timeout=0, go to RESP.
  - Watchdog reaches TIMEOUT-1 without done: result=0, err=1, timeout=1, go to RESP.
  - eng_done on the same cycle as the watchdog limit: done wins, timeout=0.
- RESP: ack of the granted requester is high for this cycle only. Update the last-served pointer, then go to IDLE.
- A request that arrives while busy stays pending and is considered in the next IDLE. Requests are never dropped.
- The requester deasserts req on the edge where it samples ack. A req still high in IDLE after that edge is a new request.
- eng_a/eng_b hold their granted values from ISSUE through RESP.
- eng_done/eng_err are ignored outside WAIT.
- Watchdog counter width is clog2(TIMEOUT).

## Timing
- Reset (asynchronous, reset=0): state IDLE; all outputs 0 (ack0, ack1, result, err, timeout, busy, eng_start, eng_a, eng_b); watchdog 0; pointer 1.
- Reset mid-operation: return to IDLE immediately, no ack is issued, and the in-flight operation is lost. The engine shares the same reset.
- req sampled high at edge k: ISSUE (eng_start=1) during cycle k+1, WAIT from k+2.
- eng_done sampled at edge m: RESP (ack=1) during cycle m+1, IDLE at m+2.
- Minimum request-to-ack latency is 4 cycles when the engine answers in the first WAIT cycle.
- Back-to-back: a pending request gets eng_start 2 cycles after the previous ack.
- All outputs are registered; no combinational path from any input to any output.

## Structure
- Shared package op_sched_pkg: state enum (IDLE, ISSUE, WAIT, RESP), requester id constants REQ0=0 and REQ1=1, operand width 4, result width 16.
- Sub-module rr_arbiter2: 2-way round-robin grant from req0, req1 and the last-served pointer. It is combinational, and the pointer is held in op_scheduler.
- Everything else (FSM, watchdog, output registers) lives in op_scheduler.

## Test plan
The engine model returns C=A*B with eng_err=1 when A=15, after a programmable delay.
- Single request: req0 with a0=2, b0=1, delay 3 → eng_start one cycle, eng_a=2, eng_b=1; ack0 pulse with result=2, err=0; ack1 never high.
- Tie: req0 (4,4) and req1 (3,5) raised in the same cycle → requester 0 served first (result 16), then requester 1 (result 15); ack0 precedes ack1.
- Fairness: req0 and req1 held continuously for 6 operations → ack0 and ack1 strictly alternate.
- Error: req1 with (15,8) → ack1 with err=1, timeout=0, result=120.
- Timeout: engine never asserts done, TIMEOUT=8 → ack exactly 8 cycles after WAIT is entered, with result=0, err=1, timeout=1.
- Reset mid-WAIT: reset=0 during WAIT → all outputs 0 at once and no ack. After release, a new req0 (7,9) completes with result=63.
